// File: rtl/layer_scheduler.sv
// LeNet feature-extraction sequencer: C1 conv -> S2 pool -> C3 conv -> S4 pool.
// Optional per-layer cycle counter under `LAYER_PERF_EN.
module layer_scheduler #(
  parameter int              NUM_LAYERS = 4,
  parameter int              TO_W       = 20,
  parameter logic [TO_W-1:0] TO_LIMIT   = 20'hFFFFF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic       conv_enable,
  input  logic       conv_end,
  output logic       pool_enable,
  input  logic       pool_end,
  output logic [7:0] size_act,
  output logic [7:0] size_kernel,
  output logic [7:0] number_feature,
  output logic       bank_sel,
  output logic [1:0] layer_idx,
  output logic       busy,
  output logic       done,
  output logic       error
`ifdef LAYER_PERF_EN
  ,
  output logic [31:0] layer_cycles,
  output logic        layer_cycles_vld
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_KICK,
    S_WAIT,
    S_NEXT,
    S_FIN,
    S_ERR
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [TO_W-1:0] r_wd;
  logic [7:0]      r_act;
  logic [7:0]      r_kern;
  logic [7:0]      r_feat;
  logic            r_bank;
  logic [1:0]      r_idx;

  logic [7:0]      w_act;
  logic [7:0]      w_kern;
  logic [7:0]      w_feat;
  logic            w_conv;
  logic            w_end;
  logic            w_last;
  logic            w_to_idle;

  always_comb begin
    w_conv = 1'b0;
    w_act  = 8'd0;
    w_kern = 8'd0;
    w_feat = 8'd0;
    unique case (r_idx)
      2'd0: begin w_conv = 1'b1; w_act = 8'd32; w_kern = 8'd5; w_feat = 8'd6;  end
      2'd1: begin w_conv = 1'b0; w_act = 8'd28; w_kern = 8'd2; w_feat = 8'd6;  end
      2'd2: begin w_conv = 1'b1; w_act = 8'd14; w_kern = 8'd5; w_feat = 8'd16; end
      2'd3: begin w_conv = 1'b0; w_act = 8'd10; w_kern = 8'd2; w_feat = 8'd16; end
    endcase
  end

  // only the unit that was kicked may end the layer
  assign w_end  = w_conv ? conv_end : pool_end;
  assign w_last = (r_idx == 2'(NUM_LAYERS - 1));

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (start) w_next = S_LOAD;
      S_LOAD: w_next = S_KICK;
      S_KICK: w_next = S_WAIT;
      S_WAIT: begin
        if (w_end)                 w_next = S_NEXT;
        else if (r_wd == TO_LIMIT) w_next = S_ERR;
      end
      S_NEXT: w_next = w_last ? S_FIN : S_LOAD;
      S_FIN:  w_next = S_IDLE;
      S_ERR:  w_next = S_ERR;
      default: w_next = S_IDLE;
    endcase
    if (abort) w_next = S_IDLE;
  end

  assign w_to_idle = (r_state != S_IDLE) && (w_next == S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_wd    <= '0;
      r_act   <= 8'd0;
      r_kern  <= 8'd0;
      r_feat  <= 8'd0;
      r_bank  <= 1'b0;
      r_idx   <= 2'd0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && w_next == S_LOAD) begin
        r_idx  <= 2'd0;
        r_bank <= 1'b0;
      end
      if (r_state == S_NEXT && w_next == S_LOAD) begin
        r_idx  <= r_idx + 2'd1;
        r_bank <= ~r_bank;
      end
      if (r_state == S_LOAD && w_next == S_KICK) begin
        r_act  <= w_act;
        r_kern <= w_kern;
        r_feat <= w_feat;
      end
      if (w_to_idle) begin
        r_act  <= 8'd0;
        r_kern <= 8'd0;
        r_feat <= 8'd0;
      end
      if (r_state == S_KICK)      r_wd <= '0;
      else if (r_state == S_WAIT) r_wd <= r_wd + 1'b1;
    end
  end

  assign conv_enable    = (r_state == S_KICK) &  w_conv;
  assign pool_enable    = (r_state == S_KICK) & ~w_conv;
  assign size_act       = r_act;
  assign size_kernel    = r_kern;
  assign number_feature = r_feat;
  assign bank_sel       = r_bank;
  assign layer_idx      = r_idx;
  assign busy           = (r_state != S_IDLE);
  assign done           = (r_state == S_FIN);
  assign error          = (r_state == S_ERR);

`ifdef LAYER_PERF_EN
  logic [31:0] r_cyc;
  logic [31:0] r_lc;
  logic        r_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cyc <= 32'd0;
      r_lc  <= 32'd0;
      r_vld <= 1'b0;
    end else begin
      r_vld <= 1'b0;
      if (r_state == S_KICK)
        r_cyc <= 32'd1;
      else if (r_state == S_WAIT && r_cyc != 32'hFFFFFFFF)
        r_cyc <= r_cyc + 32'd1;
      if (r_state == S_NEXT && !abort) begin
        r_lc  <= r_cyc;
        r_vld <= 1'b1;
      end
    end
  end

  assign layer_cycles     = r_lc;
  assign layer_cycles_vld = r_vld;
`endif

endmodule

// File: tb/tb_layer_scheduler.sv
// Directed bench for layer_scheduler: layer table walk, ignored ends,
// watchdog, abort and async reset; perf counter under `LAYER_PERF_EN.
module tb_layer_scheduler;

  typedef struct {
    bit         conv;
    logic [7:0] act;
    logic [7:0] kern;
    logic [7:0] feat;
    logic       bank;
    logic [1:0] idx;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic       conv_enable;
  logic       conv_end;
  logic       pool_enable;
  logic       pool_end;
  logic [7:0] size_act;
  logic [7:0] size_kernel;
  logic [7:0] number_feature;
  logic       bank_sel;
  logic [1:0] layer_idx;
  logic       busy;
  logic       done;
  logic       error;
`ifdef LAYER_PERF_EN
  logic [31:0] layer_cycles;
  logic        layer_cycles_vld;
`endif

  int   total = 0;
  int   bad   = 0;
  int   done_cnt = 0;
  vec_t tbl[4];

  layer_scheduler #(.TO_LIMIT(20'd50)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .abort          (abort),
    .conv_enable    (conv_enable),
    .conv_end       (conv_end),
    .pool_enable    (pool_enable),
    .pool_end       (pool_end),
    .size_act       (size_act),
    .size_kernel    (size_kernel),
    .number_feature (number_feature),
    .bank_sel       (bank_sel),
    .layer_idx      (layer_idx),
    .busy           (busy),
    .done           (done),
    .error          (error)
`ifdef LAYER_PERF_EN
    ,
    .layer_cycles     (layer_cycles),
    .layer_cycles_vld (layer_cycles_vld)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic reply(input bit c);
    step();
    chk("en_1cyc", {30'd0, conv_enable, pool_enable}, 0);
    repeat (9) step();
    if (c) conv_end = 1'b1;
    else   pool_end = 1'b1;
    step();
    conv_end = 1'b0;
    pool_end = 1'b0;
  endtask

  task automatic go_to_kick(input int layer);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    for (int i = 0; i < layer; i++) begin
      reply(tbl[i].conv);
      step();
      step();
    end
  endtask

  task automatic do_abort();
    abort = 1'b1;
    step();
    abort = 1'b0;
  endtask

  initial begin
    int n;
    int dsave;
    tbl[0] = '{1'b1, 8'd32, 8'd5, 8'd6,  1'b0, 2'd0};
    tbl[1] = '{1'b0, 8'd28, 8'd2, 8'd6,  1'b1, 2'd1};
    tbl[2] = '{1'b1, 8'd14, 8'd5, 8'd16, 1'b0, 2'd2};
    tbl[3] = '{1'b0, 8'd10, 8'd2, 8'd16, 1'b1, 2'd3};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    conv_end = 1'b0; pool_end = 1'b0;
    repeat (3) step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err",  error, 0);
    chk("rst_act",  size_act, 0);
    chk("rst_feat", number_feature, 0);
    chk("rst_en",   {conv_enable, pool_enable}, 0);
    rst_n = 1'b1;
    step();

    // full run: start -> LOAD -> KICK
    start = 1'b1;
    step();
    start = 1'b0;
    chk("load_en", {conv_enable, pool_enable}, 0);
    chk("load_busy", busy, 1);
    step();
    for (int i = 0; i < 4; i++) begin
      chk("kick_conv", conv_enable, tbl[i].conv);
      chk("kick_pool", pool_enable, !tbl[i].conv);
      chk("cfg_act",   size_act, tbl[i].act);
      chk("cfg_kern",  size_kernel, tbl[i].kern);
      chk("cfg_feat",  number_feature, tbl[i].feat);
      chk("bank",      bank_sel, tbl[i].bank);
      chk("idx",       layer_idx, tbl[i].idx);
      reply(tbl[i].conv);
      step();
`ifdef LAYER_PERF_EN
      chk("perf_cyc", layer_cycles, 11);
      chk("perf_vld", layer_cycles_vld, 1);
`endif
      if (i < 3) begin
        chk("mid_done", done, 0);
        step();
`ifdef LAYER_PERF_EN
        chk("perf_vld_off", layer_cycles_vld, 0);
`endif
      end else begin
        chk("fin_done", done, 1);
        step();
        chk("idle_done", done, 0);
        chk("idle_busy", busy, 0);
        chk("idle_act", size_act, 0);
      end
    end
    chk("done_once", done_cnt, 1);

    // wrong-unit end ignored while pool layer waits
    go_to_kick(1);
    repeat (3) step();
    conv_end = 1'b1;
    step();
    conv_end = 1'b0;
    step();
    chk("ign_idx", layer_idx, 1);
    chk("ign_busy", busy, 1);
    chk("ign_en", {conv_enable, pool_enable}, 0);
    pool_end = 1'b1;
    step();
    pool_end = 1'b0;
    step();
    chk("adv_idx", layer_idx, 2);
    chk("adv_bank", bank_sel, 0);
    do_abort();
    chk("ab1_busy", busy, 0);

    // watchdog expiry
    go_to_kick(0);
    n = 0;
    while (!error && n < 100) begin
      step();
      n++;
    end
    chk("to_cycles", n, 52);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("err_hold", error, 1);
    chk("err_busy", busy, 1);
    chk("err_en", {conv_enable, pool_enable}, 0);
    do_abort();
    chk("err_clr", error, 0);
    chk("err_idle", busy, 0);

    // end on the limit cycle beats the timeout
    go_to_kick(0);
    repeat (51) step();
    conv_end = 1'b1;
    step();
    conv_end = 1'b0;
    chk("lim_err", error, 0);
    chk("lim_busy", busy, 1);
    step();
    step();
    chk("lim_next", pool_enable, 1);
    do_abort();

    // abort with pool_end in the last layer
    dsave = done_cnt;
    go_to_kick(3);
    repeat (4) step();
    abort = 1'b1;
    pool_end = 1'b1;
    step();
    abort = 1'b0;
    pool_end = 1'b0;
    chk("ab_busy", busy, 0);
    chk("ab_done", done, 0);
    chk("ab_act", size_act, 0);
    chk("ab_kern", size_kernel, 0);
    step();
    step();
    chk("ab_nodone", done_cnt, dsave);

    // async reset mid-WAIT of layer 1
    go_to_kick(1);
    repeat (3) step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_busy", busy, 0);
    chk("ar_bank", bank_sel, 0);
    chk("ar_idx",  layer_idx, 0);
    chk("ar_act",  size_act, 0);
    chk("ar_feat", number_feature, 0);
    step();
    rst_n = 1'b1;
    step();
    chk("ar_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
